// File: rtl/timer0_pkg.sv
// Shared encodings and constants for the Timer/Counter0 counter, compare and waveform stage.
package timer0_pkg;

    localparam int TIMER_WIDTH = 8;

    typedef enum logic [1:0] {
        WGM_NORMAL   = 2'b00,
        WGM_PWM_PC   = 2'b01,
        WGM_CTC      = 2'b10,
        WGM_FAST_PWM = 2'b11
    } wgm_e;

    typedef enum logic [1:0] {
        COM_OFF    = 2'b00,
        COM_TOGGLE = 2'b01,
        COM_CLEAR  = 2'b10,
        COM_SET    = 2'b11
    } com_e;

    localparam logic [TIMER_WIDTH-1:0] TOP    = '1;
    localparam logic [TIMER_WIDTH-1:0] BOTTOM = '0;

    function automatic logic is_pwm(input wgm_e mode);
        return (mode == WGM_PWM_PC) || (mode == WGM_FAST_PWM);
    endfunction

endpackage

// File: rtl/timer0_waveform_gen.sv
// OC0 output latch: decodes COM/FOC per waveform mode into set, clear or toggle actions.
module timer0_waveform_gen
    import timer0_pkg::*;
(
    input  logic sysClock,
    input  logic reset,
    input  wgm_e mode,
    input  com_e com,
    input  logic foc,
    input  logic match,
    input  logic wrap,
    input  logic dir,
    output logic oc0
);

    logic oc0_q;
    logic oc0_next;
    logic out_en;
    logic pwm_active;

    assign pwm_active = (com == COM_CLEAR) || (com == COM_SET);

    always_comb begin
        // NOTE: default assignment first so every path drives oc0_next and no latch is inferred.
        oc0_next = oc0_q;
        case (mode)
            WGM_FAST_PWM: begin
                // The wrap action wins over a match at TOP so OCR0 = TOP gives a steady level.
                if (pwm_active) begin
                    if (wrap)
                        oc0_next = (com == COM_CLEAR);
                    else if (match)
                        oc0_next = (com == COM_SET);
                end
            end
            WGM_PWM_PC: begin
                if (pwm_active && match)
                    oc0_next = (com == COM_CLEAR) ? dir : !dir;
            end
            default: begin
                if (match || foc) begin
                    case (com)
                        COM_TOGGLE: oc0_next = !oc0_q;
                        COM_CLEAR:  oc0_next = 1'b0;
                        COM_SET:    oc0_next = 1'b1;
                        default:    oc0_next = oc0_q;
                    endcase
                end
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments; reset is synchronous and active-high.
    always_ff @(posedge sysClock) begin
        if (reset)
            oc0_q <= 1'b0;
        else
            oc0_q <= oc0_next;
    end

    assign out_en = (com != COM_OFF) && !(is_pwm(mode) && (com == COM_TOGGLE));
    assign oc0    = oc0_q & out_en;

endmodule

// File: rtl/timer0_counter_unit.sv
// TCNT0/OCR0 counter and compare stage of Timer/Counter0 with TOV0/OCF0 flags and OC0 output.
module timer0_counter_unit
    import timer0_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             sysClock,
    input  logic             reset,
    input  logic             tick,
    input  logic [1:0]       wgm,
    input  logic [1:0]       com,
    input  logic             foc,
    input  logic             tcnt_wr,
    input  logic [WIDTH-1:0] tcnt_wdata,
    input  logic             ocr_wr,
    input  logic [WIDTH-1:0] ocr_wdata,
    input  logic [1:0]       flag_clr,
    output logic [WIDTH-1:0] tcnt,
    output logic [WIDTH-1:0] ocr,
    output logic             tov,
    output logic             ocf,
    output logic             oc0,
    output logic             dir
);

    localparam logic [WIDTH-1:0] CNT_TOP    = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_BOTTOM = '0;
    localparam logic [WIDTH-1:0] CNT_ONE    = WIDTH'(1);

    wgm_e mode;
    assign mode = wgm_e'(wgm);

    logic [WIDTH-1:0] tcnt_q, tcnt_next;
    logic [WIDTH-1:0] ocr_buf_q, ocr_act_q;
    logic             tov_q, ocf_q, dir_q, dir_next, block_q;
    logic             cnt_tick, at_top, at_bottom, match;
    logic             tov_set, ocr_update, wrap;

    // A CPU write to TCNT0 swallows the tick of that cycle.
    assign cnt_tick  = tick && !tcnt_wr;
    assign at_top    = (tcnt_q == CNT_TOP);
    assign at_bottom = (tcnt_q == CNT_BOTTOM);
    assign match     = cnt_tick && (tcnt_q == ocr_act_q) && !block_q;

    always_comb begin
        tcnt_next  = tcnt_q;
        dir_next   = (mode == WGM_PWM_PC) ? dir_q : 1'b0;
        tov_set    = 1'b0;
        ocr_update = 1'b0;
        wrap       = 1'b0;
        if (cnt_tick) begin
            case (mode)
                WGM_NORMAL: begin
                    tcnt_next = tcnt_q + CNT_ONE;
                    tov_set   = at_top;
                end
                WGM_CTC: begin
                    tcnt_next = match ? CNT_BOTTOM : tcnt_q + CNT_ONE;
                    tov_set   = at_top;
                end
                WGM_FAST_PWM: begin
                    if (at_top) begin
                        tcnt_next  = CNT_BOTTOM;
                        tov_set    = 1'b1;
                        ocr_update = 1'b1;
                        wrap       = 1'b1;
                    end else begin
                        tcnt_next = tcnt_q + CNT_ONE;
                    end
                end
                default: begin
                    if (!dir_q) begin
                        if (at_top) begin
                            tcnt_next  = CNT_TOP - CNT_ONE;
                            dir_next   = 1'b1;
                            ocr_update = 1'b1;
                        end else begin
                            tcnt_next = tcnt_q + CNT_ONE;
                        end
                    end else if (at_bottom) begin
                        tcnt_next = CNT_ONE;
                        dir_next  = 1'b0;
                        tov_set   = 1'b1;
                    end else begin
                        tcnt_next = tcnt_q - CNT_ONE;
                    end
                end
            endcase
        end
        if (tcnt_wr)
            tcnt_next = tcnt_wdata;
    end

    always_ff @(posedge sysClock) begin
        if (reset) begin
            tcnt_q    <= '0;
            ocr_buf_q <= '0;
            ocr_act_q <= '0;
            tov_q     <= 1'b0;
            ocf_q     <= 1'b0;
            dir_q     <= 1'b0;
            block_q   <= 1'b0;
        end else begin
            tcnt_q <= tcnt_next;
            dir_q  <= dir_next;

            if (tcnt_wr)
                block_q <= 1'b1;
            else if (cnt_tick)
                block_q <= 1'b0;

            // In PWM modes the compare register is double-buffered and reloads at the update point.
            if (ocr_wr) begin
                ocr_buf_q <= ocr_wdata;
                if (!is_pwm(mode) || ocr_update)
                    ocr_act_q <= ocr_wdata;
            end else if (ocr_update) begin
                ocr_act_q <= ocr_buf_q;
            end

            tov_q <= tov_set | (tov_q & ~flag_clr[0]);
            ocf_q <= match   | (ocf_q & ~flag_clr[1]);
        end
    end

    timer0_waveform_gen u_waveform_gen (
        .sysClock (sysClock),
        .reset    (reset),
        .mode     (mode),
        .com      (com_e'(com)),
        .foc      (foc),
        .match    (match),
        .wrap     (wrap),
        .dir      (dir_q),
        .oc0      (oc0)
    );

    assign tcnt = tcnt_q;
    assign ocr  = ocr_buf_q;
    assign tov  = tov_q;
    assign ocf  = ocf_q;
    assign dir  = dir_q;

endmodule
